// File: rtl/vga_display_pipe.sv
// VGA timing generator with lookup-latency-matched palette output.
// Optional screen border: define VGA_BORDER_EN.
module vga_display_pipe #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 4,
    parameter int LOOKUP_LAT = 2,
    parameter int COLOR_W    = 4,
    parameter int BORDER_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         state,
    input  logic [2:0]         pix_class,
    output logic               pix_tick,
    output logic               req,
    output logic [9:0]         x_pos,
    output logic [9:0]         y_pos,
    output logic               frame_start,
    output logic               h_sync,
    output logic               v_sync,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HCW = $clog2(H_TOTAL);
    localparam int VCW = $clog2(V_TOTAL);
    localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int L   = LOOKUP_LAT;

    localparam logic [DCW-1:0] D_LAST = DCW'(CLK_DIV - 1);
    localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_SE   = HCW'(H_SYNC);
    localparam logic [HCW-1:0] H_A0   = HCW'(H_SYNC + H_BP);
    localparam logic [HCW-1:0] H_A1   = HCW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_SE   = VCW'(V_SYNC);
    localparam logic [VCW-1:0] V_A0   = VCW'(V_SYNC + V_BP);
    localparam logic [VCW-1:0] V_A1   = VCW'(V_SYNC + V_BP + V_ACTIVE);

    logic [DCW-1:0] r_div;
    logic [HCW-1:0] r_h;
    logic [VCW-1:0] r_v;
    logic           w_tick;
    logic           w_h_wrap;
    logic           w_v_wrap;
    logic           w_act;
    logic           w_hs_on;
    logic           w_vs_on;

    // Gated by rst so CLK_DIV=1 still reports no tick while held in reset
    assign w_tick   = rst && (r_div == D_LAST);
    assign w_h_wrap = (r_h == H_LAST);
    assign w_v_wrap = (r_v == V_LAST);
    assign w_hs_on  = (r_h < H_SE);
    assign w_vs_on  = (r_v < V_SE);
    assign w_act    = (r_h >= H_A0) && (r_h < H_A1) &&
                      (r_v >= V_A0) && (r_v < V_A1);

    assign pix_tick    = w_tick;
    assign frame_start = w_tick && w_h_wrap && w_v_wrap;
    assign req         = w_act;
    assign x_pos       = w_act ? 10'(r_h - H_A0) : '0;
    assign y_pos       = w_act ? 10'(r_v - V_A0) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (r_div == D_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_tick) begin
            if (w_h_wrap) begin
                r_h <= '0;
                r_v <= w_v_wrap ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Sync is carried as "in pulse" so cleared stages mean idle-high outputs
    logic [L-1:0] r_p_act;
    logic [L-1:0] r_p_hs;
    logic [L-1:0] r_p_vs;
`ifdef VGA_BORDER_EN
    logic [L-1:0][9:0] r_p_x;
    logic [L-1:0][9:0] r_p_y;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p_act <= '0;
            r_p_hs  <= '0;
            r_p_vs  <= '0;
`ifdef VGA_BORDER_EN
            r_p_x   <= '0;
            r_p_y   <= '0;
`endif
        end else if (w_tick) begin
            r_p_act[0] <= w_act;
            r_p_hs[0]  <= w_hs_on;
            r_p_vs[0]  <= w_vs_on;
`ifdef VGA_BORDER_EN
            r_p_x[0]   <= x_pos;
            r_p_y[0]   <= y_pos;
`endif
            for (int i = 1; i < L; i++) begin
                r_p_act[i] <= r_p_act[i-1];
                r_p_hs[i]  <= r_p_hs[i-1];
                r_p_vs[i]  <= r_p_vs[i-1];
`ifdef VGA_BORDER_EN
                r_p_x[i]   <= r_p_x[i-1];
                r_p_y[i]   <= r_p_y[i-1];
`endif
            end
        end
    end

    function automatic logic [11:0] f_pal(
        input logic [2:0] c,
        input logic [1:0] s
    );
        logic [11:0] p;
        case (c)
            3'd0:    p = 12'h000;
            3'd1:    p = 12'h888;
            3'd2:    p = 12'h0F0;
            3'd3:    p = 12'h0A0;
            3'd4:    p = 12'hF80;
            default: p = 12'hFFF;
        endcase
        if (s == 2'b11 && c != 3'd0) begin
            p = 12'hF00;
        end else if (s == 2'b10) begin
            p = {1'b0, p[11:9], 1'b0, p[7:5], 1'b0, p[3:1]};
        end
        return p;
    endfunction

    function automatic logic [COLOR_W-1:0] f_exp(input logic [3:0] c);
        return COLOR_W'(c) << (COLOR_W - 4);
    endfunction

    logic [11:0] w_pix;

`ifdef VGA_BORDER_EN
    localparam logic [9:0] BW = 10'(BORDER_W);
    localparam logic [9:0] XR = 10'(H_ACTIVE - BORDER_W);
    localparam logic [9:0] YR = 10'(V_ACTIVE - BORDER_W);
    logic w_border;
    assign w_border = (r_p_x[L-1] < BW) || (r_p_x[L-1] >= XR) ||
                      (r_p_y[L-1] < BW) || (r_p_y[L-1] >= YR);
`endif

    always_comb begin
        w_pix = f_pal(pix_class, state);
`ifdef VGA_BORDER_EN
        if (w_border) begin
            w_pix = 12'hFFF;
        end
`endif
        if (!r_p_act[L-1]) begin
            w_pix = 12'h000;
        end
    end

    logic               r_hs;
    logic               r_vs;
    logic [COLOR_W-1:0] r_r;
    logic [COLOR_W-1:0] r_g;
    logic [COLOR_W-1:0] r_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hs <= 1'b1;
            r_vs <= 1'b1;
            r_r  <= '0;
            r_g  <= '0;
            r_b  <= '0;
        end else if (w_tick) begin
            r_hs <= ~r_p_hs[L-1];
            r_vs <= ~r_p_vs[L-1];
            r_r  <= f_exp(w_pix[11:8]);
            r_g  <= f_exp(w_pix[7:4]);
            r_b  <= f_exp(w_pix[3:0]);
        end
    end

    assign h_sync = r_hs;
    assign v_sync = r_vs;
    assign r      = r_r;
    assign g      = r_g;
    assign b      = r_b;

endmodule

// File: tb/tb_vga_display_pipe.sv
// Scoreboard bench for vga_display_pipe on a reduced 25x17 raster.
// Expected pixels keyed by tick-edge count since reset release.
module tb_vga_display_pipe;

    localparam int CW = 4;
`ifdef VGA_BORDER_EN
    localparam bit BORD = 1'b1;
`else
    localparam bit BORD = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [1:0]    state;
    logic [2:0]    pix_class;
    logic          pix_tick;
    logic          req;
    logic [9:0]    x_pos;
    logic [9:0]    y_pos;
    logic          frame_start;
    logic          h_sync;
    logic          v_sync;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;

    vga_display_pipe #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .CLK_DIV(4), .LOOKUP_LAT(2), .COLOR_W(CW), .BORDER_W(2)
    ) dut (
        .clk(clk), .rst(rst), .state(state), .pix_class(pix_class),
        .pix_tick(pix_tick), .req(req), .x_pos(x_pos), .y_pos(y_pos),
        .frame_start(frame_start), .h_sync(h_sync), .v_sync(v_sync),
        .r(r), .g(g), .b(b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          key;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    typedef struct {
        int       key;
        logic     rq;
        logic [9:0] x;
        logic [9:0] y;
    } crd_t;

    exp_t out_q[$];
    crd_t crd_q[$];
    int   fs_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tcount = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void push_o(input int k, input logic hs,
                                   input logic vs, input logic [11:0] c);
        exp_t e;
        e.key = k; e.hs = hs; e.vs = vs; e.rgb = c;
        out_q.push_back(e);
    endfunction

    function automatic void push_c(input int k, input logic rq,
                                   input int x, input int y);
        crd_t e;
        e.key = k; e.rq = rq; e.x = 10'(x); e.y = 10'(y);
        crd_q.push_back(e);
    endfunction

    // Lookup model: class = x_pos[2:0] when active, 7 otherwise
    initial begin
        logic [2:0] d0;
        logic [2:0] nc;
        d0 = '0;
        pix_class = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                d0 = '0;
                pix_class = '0;
                continue;
            end
            if (!pix_tick) continue;
            nc = req ? x_pos[2:0] : 3'd7;
            @(posedge clk);
            #1;
            if (!rst) continue;
            pix_class = d0;
            d0 = nc;
        end
    end

    // Monitor: coordinates/frame_start in tick cycles, outputs after tick edges
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                tcount = 0;
                continue;
            end
            if (!pix_tick) continue;
            while (crd_q.size() > 0 && crd_q[0].key < tcount) begin
                chk("coord_missed", tcount, crd_q[0].key);
                void'(crd_q.pop_front());
            end
            if (crd_q.size() > 0 && crd_q[0].key == tcount) begin
                chk("req", req, crd_q[0].rq);
                chk("x_pos", x_pos, crd_q[0].x);
                chk("y_pos", y_pos, crd_q[0].y);
                void'(crd_q.pop_front());
            end
            while (fs_q.size() > 0 && fs_q[0] < tcount) begin
                chk("frame_start_missed", tcount, fs_q[0]);
                void'(fs_q.pop_front());
            end
            if (frame_start) begin
                if (fs_q.size() > 0) begin
                    chk("frame_start_tick", tcount, fs_q[0]);
                    void'(fs_q.pop_front());
                end else begin
                    chk("frame_start_extra", frame_start, 0);
                end
            end
            @(posedge clk);
            #1;
            if (!rst) continue;
            tcount++;
            while (out_q.size() > 0 && out_q[0].key < tcount) begin
                chk("out_missed", tcount, out_q[0].key);
                void'(out_q.pop_front());
            end
            if (out_q.size() > 0 && out_q[0].key == tcount) begin
                chk($sformatf("h_sync@%0d", tcount), h_sync, out_q[0].hs);
                chk($sformatf("v_sync@%0d", tcount), v_sync, out_q[0].vs);
                chk($sformatf("rgb@%0d", tcount), {r, g, b}, out_q[0].rgb);
                void'(out_q.pop_front());
            end
        end
    end

    task automatic wait_tick(input int tgt);
        int n;
        n = 0;
        while (tcount < tgt && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (tcount < tgt) chk("timeout", tcount, tgt);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_hsync"}, h_sync, 1);
        chk({p, "_vsync"}, v_sync, 1);
        chk({p, "_rgb"}, {r, g, b}, 0);
        chk({p, "_req"}, req, 0);
        chk({p, "_xy"}, {x_pos, y_pos}, 0);
        chk({p, "_tick"}, pix_tick, 0);
        chk({p, "_fs"}, frame_start, 0);
    endtask

    initial begin
        rst = 1'b0;
        state = 2'b01;

        // Frame 0, state play; key = tick n + 3 for coordinate shown at tick n
        push_o(2, 1, 1, 12'h000);
        push_o(3, 0, 0, 12'h000);
        push_o(6, 0, 0, 12'h000);
        push_o(7, 1, 0, 12'h000);
        push_o(56, 0, 1, 12'h000);
        push_o(57, 1, 1, 12'h000);
        push_o(110, 1, 1, BORD ? 12'hFFF : 12'h000);
        push_o(209, 1, 1, 12'h000);
        push_o(210, 1, 1, BORD ? 12'hFFF : 12'h000);
        push_o(212, 1, 1, 12'h0F0);
        push_o(213, 1, 1, 12'h0A0);
        push_o(214, 1, 1, 12'hF80);
        push_o(215, 1, 1, 12'hFFF);
        push_o(226, 1, 1, 12'h000);
        push_o(318, 1, 1, 12'h000);
        push_o(400, 1, 1, 12'hFFF);
        // Frame 1, game over
        push_o(635, 1, 1, BORD ? 12'hFFF : 12'h000);
        push_o(636, 1, 1, BORD ? 12'hFFF : 12'hF00);
        push_o(637, 1, 1, 12'hF00);
        push_o(639, 1, 1, 12'hF00);
        // Frame 2, pause
        push_o(1060, 1, 1, BORD ? 12'hFFF : 12'h000);
        push_o(1062, 1, 1, 12'h070);
        push_o(1063, 1, 1, 12'h050);
        push_o(1064, 1, 1, 12'h740);
        push_o(1066, 1, 1, 12'h777);

        push_c(0, 0, 0, 0);
        push_c(206, 0, 0, 0);
        push_c(207, 1, 0, 4);
        push_c(209, 1, 2, 4);
        push_c(222, 1, 15, 4);
        push_c(223, 0, 0, 0);
        push_c(397, 1, 15, 11);
        push_c(424, 0, 0, 0);
        fs_q.push_back(424);
        fs_q.push_back(849);

        repeat (10) @(posedge clk);
        #1;
        chk_reset_vals("rst");

        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("tick_clk1", pix_tick, 0);
        @(negedge clk);
        chk("tick_clk2", pix_tick, 0);
        @(negedge clk);
        chk("tick_clk3", pix_tick, 1);

        wait_tick(500);
        state = 2'b11;
        wait_tick(900);
        state = 2'b10;
        wait_tick(1110);
        chk("drain1", out_q.size() + crd_q.size() + fs_q.size(), 0);

        // Abort mid-line while an active pixel is on screen
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        state = 2'b01;
        push_o(2, 1, 1, 12'h000);
        push_o(3, 0, 0, 12'h000);
        push_o(7, 1, 0, 12'h000);
        push_o(212, 1, 1, 12'h0F0);
        push_c(0, 0, 0, 0);
        push_c(209, 1, 2, 4);
        fs_q.push_back(424);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        wait_tick(430);
        chk("drain2", out_q.size() + crd_q.size() + fs_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
